cpu16_divider: RTL and testbench

//   Iterative 16-bit divider: the inverse companion of the cpu16 ALU multiply op.

---
 rtl/cpu16_divider.sv | 159 +++++++++++++++
 tb/tb_cpu16_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu16_divider.sv
// Iterative radix-2 restoring divider, signed or unsigned, producing quotient, remainder and divide-by-zero flag.
// Latency: done is high WIDTH+2 edges after the accept edge (the accept edge counts as the first); after divide-by-zero it is high in the cycle right after the accept edge.
// Backpressure: start is ignored while busy (RUN/FIX); results are held until the next done.
module cpu16_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;     // one extra bit keeps the compare from overflowing
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] div_q, div_d;     // divisor magnitude
  logic             sgn_q, sgn_d;
  logic             xneg_q, xneg_d;
  logic             yneg_q, yneg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_lo;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic             accept;

  // Operand magnitudes, the shifted partial remainder and the accept condition.
  always_comb begin
    x_mag  = (sgn && x[WIDTH-1]) ? -x : x;
    y_mag  = (sgn && y[WIDTH-1]) ? -y : y;
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_lo = rem_q[WIDTH-1:0];
    accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    xneg_d  = xneg_q;
    yneg_d  = yneg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      S_RUN: begin
        // One restoring step: shift in the next dividend bit, subtract if it fits.
        if (rem_sh >= {1'b0, div_q}) begin
          rem_d = rem_sh - {1'b0, div_q};
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        // Quotient negative when signs differ; remainder follows the dividend.
        q_d     = (sgn_q && (xneg_q ^ yneg_q)) ? -quo_q : quo_q;
        r_d     = (sgn_q && xneg_q) ? -rem_lo : rem_lo;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepting overrides the IDLE/DONE behaviour above.
    if (accept) begin
      sgn_d  = sgn;
      xneg_d = sgn && x[WIDTH-1];
      yneg_d = sgn && y[WIDTH-1];
      rem_d  = '0;
      quo_d  = x_mag;
      div_d  = y_mag;
      cnt_d  = CW'(WIDTH - 1);
      if (y == '0) begin
        // Divide by zero bypasses the iteration entirely.
        q_d     = '1;
        r_d     = x;
        dz_d    = 1'b1;
        state_d = S_DONE;
      end else begin
        dz_d    = 1'b0;
        state_d = S_RUN;
      end
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      sgn_q   <= 1'b0;
      xneg_q  <= 1'b0;
      yneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      xneg_q  <= xneg_d;
      yneg_q  <= yneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  // Status and result outputs come straight from registers.
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_FIX);
    done = (state_q == S_DONE);
    q    = q_q;
    r    = r_q;
    dz   = dz_q;
  end

endmodule

// File: tb/tb_cpu16_divider.sv
// Directed bench for cpu16_divider: table of divide vectors plus handshake and reset sequences.
// Latency: counts edges from the accept edge (as 1) until done is observed.
// Backpressure: injects ignored starts while busy and a back-to-back start in the DONE cycle.
module tb_cpu16_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        busy, done, dz;
  logic [15:0] q, r;

  int checks = 0;
  int errors = 0;

  cpu16_divider #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn), .x(x), .y(y),
    .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start an op, wait for done (bounded), optionally inject ignored starts at cycles inj1/inj2.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input int inj1, input int inj2,
                        output int n, output bit seen_busy, output bit overlap, output bit ok);
    sgn = s; x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; seen_busy = 0; overlap = 0; ok = 0;
    while (n < 40) begin
      if (busy) seen_busy = 1;
      if (busy && done) overlap = 1;
      if (done) begin
        ok = 1;
        break;
      end
      if (n == inj1 || n == inj2) begin
        start = 1'b1; sgn = 1'b1; x = 16'h1234; y = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    int  n;
    bit  sb, ov, ok;
    bit  saw_done;

    vecs.push_back('{"u100_7",     1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0});
    vecs.push_back('{"s-7_2",      1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0});
    vecs.push_back('{"s7_-2",      1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0});
    vecs.push_back('{"s-7_-2",     1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0});
    vecs.push_back('{"u_dz",       1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1});
    vecs.push_back('{"s_dz",       1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1});
    vecs.push_back('{"s_ovf",      1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
    vecs.push_back('{"uFFFF_1",    1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{"u3_FFFF",    1'b0, 16'h0003, 16'hFFFF, 16'h0000, 16'h0003, 1'b0});
    vecs.push_back('{"s8000_2",    1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0});
    vecs.push_back('{"u8000_3",    1'b0, 16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0});

    // Reset state
    reset = 1'b1;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", {16'b0, q}, 32'd0);
    chk("rst_r", {16'b0, r}, 32'd0);
    chk("rst_dz", {31'b0, dz}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, -1, -1, n, sb, ov, ok);
      chk({vecs[i].name, "_done_seen"}, {31'b0, ok}, 32'd1);
      chk({vecs[i].name, "_q"}, {16'b0, q}, {16'b0, vecs[i].eq});
      chk({vecs[i].name, "_r"}, {16'b0, r}, {16'b0, vecs[i].er});
      chk({vecs[i].name, "_dz"}, {31'b0, dz}, {31'b0, vecs[i].edz});
      chk({vecs[i].name, "_latency"}, n, vecs[i].edz ? 32'd1 : 32'd18);
      chk({vecs[i].name, "_busy_seen"}, {31'b0, sb}, vecs[i].edz ? 32'd0 : 32'd1);
      chk({vecs[i].name, "_busy_done_overlap"}, {31'b0, ov}, 32'd0);
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    end

    // Starts while busy are ignored
    run_op(1'b0, 16'h0064, 16'h0007, 5, 10, n, sb, ov, ok);
    chk("ign_done_seen", {31'b0, ok}, 32'd1);
    chk("ign_q", {16'b0, q}, 32'h000E);
    chk("ign_r", {16'b0, r}, 32'h0002);
    chk("ign_dz", {31'b0, dz}, 32'd0);
    chk("ign_latency", n, 32'd18);

    // Back-to-back start in the DONE cycle
    sgn = 1'b0; x = 16'hFFFF; y = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_done_low", {31'b0, done}, 32'd0);
    chk("b2b_q_held", {16'b0, q}, 32'h000E);
    chk("b2b_r_held", {16'b0, r}, 32'h0002);
    n = 1; ok = 0;
    while (n < 40) begin
      if (done) begin
        ok = 1;
        break;
      end
      if (q !== 16'h000E || r !== 16'h0002) begin
        chk("b2b_hold_during_run", {q, r}, 32'h000E_0002);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_done_seen", {31'b0, ok}, 32'd1);
    chk("b2b_latency", n, 32'd18);
    chk("b2b_q", {16'b0, q}, 32'hFFFF);
    chk("b2b_r", {16'b0, r}, 32'h0000);

    // Asynchronous reset mid-run
    sgn = 1'b0; x = 16'h0064; y = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_q", {16'b0, q}, 32'd0);
    chk("arst_r", {16'b0, r}, 32'd0);
    chk("arst_dz", {31'b0, dz}, 32'd0);
    #13;
    reset = 1'b0;
    saw_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("arst_no_done", {31'b0, saw_done}, 32'd0);
    run_op(1'b0, 16'h0064, 16'h0007, -1, -1, n, sb, ov, ok);
    chk("post_rst_done_seen", {31'b0, ok}, 32'd1);
    chk("post_rst_q", {16'b0, q}, 32'h000E);
    chk("post_rst_r", {16'b0, r}, 32'h0002);
    chk("post_rst_latency", n, 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
